uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with an input FIFO and a valid/ready byte interface.
//  Serialises start, data (LSB first), optional parity and 1-2 stop bits onto uart_txd.
//  Frame format is set by parameters; 8N1 is the default.
//  Serves as a board-side TX path, and as a synthesisable line driver for top-level
//  benches that currently use the send_byte task.
// PARAMETERS
//  CLK_HZ        50000000  system clock frequency in Hz
//  BIT_RATE      9600      line rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE, truncated
//  PAYLOAD_BITS  8         data bits per frame, 5..9
//  PARITY        0         0 = none, 1 = odd, 2 = even
//  STOP_BITS     1         1 or 2
//  FIFO_DEPTH    4         word slots, power of two, >= 2
// PORTS
//  clk         in   1                      system clock, all logic on rising edge
//  reset       in   1                      synchronous, active-high reset
//  s_valid     in   1                      s_data holds a word to send
//  s_ready     out  1                      FIFO can accept a word this cycle
//  s_data      in   PAYLOAD_BITS           word to transmit
//  uart_txd    out  1                      serial line, idles high
//  busy        out  1                      a frame is on the line or the FIFO is non-empty
//  fifo_level  out  $clog2(FIFO_DEPTH)+1   words held in the FIFO
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - Next edge: uart_txd=1, busy=0, fifo_level=0, FSM=IDLE, FIFO flushed.
//    - s_ready=1 from the first cycle after reset is released.
//    - Reset mid-frame aborts the frame: line returns high on that edge.
//  - Handshake:
//    - A push happens on an edge where s_valid && s_ready. s_ready = !full (combinational).
//    - A push is refused when full, even if a pop happens in the same cycle.
//    - Push and pop in the same cycle: fifo_level unchanged.
//  - FSM states and transitions:
//    - IDLE -> START when the FIFO is non-empty. The word pops on that edge and txd=0.
//    - START -> DATA. DATA runs PAYLOAD_BITS bits, LSB first.
//    - DATA -> PARITY if PARITY != 0, else DATA -> STOP.
//    - PARITY -> STOP. STOP runs STOP_BITS bits at txd=1.
//    - After STOP: -> START if the FIFO is non-empty, else -> IDLE. Back-to-back frames have zero idle gap.
//  - Latency: a push into an empty, idle block takes 1 cycle to the txd falling edge.
//  - Bit timing:
//    - Every bit (start, data, parity, stop) lasts exactly CYCLES_PER_BIT clocks.
//    - The bit counter uses $clog2(CYCLES_PER_BIT) bits and wraps to 0 at CYCLES_PER_BIT-1.
//  - Parity:
//    - even: parity bit = ^data.
//    - odd:  parity bit = ~^data.
//    - Taken from the latched shift register, never from s_data.
//  - busy = (state != IDLE) || (fifo_level != 0). It falls on the edge that ends the last stop bit.
//  - uart_txd is a registered output; no glitches.
// STRUCTURE
//  - Shared header uart_defs.vh holds:
//    - PARITY_NONE/ODD/EVEN encodings
//    - FSM state encodings (IDLE, START, DATA, PARITY, STOP)
//    - a CYCLES_PER_BIT helper macro
//  - Sub-module uart_sync_fifo (WIDTH, DEPTH): single-clock, registered read,
//    full/empty/level outputs.
//  - Top holds the FSM, bit-period counter, bit index and shift register.
// TESTING  (CLK_HZ=50000000, BIT_RATE=9600 -> 5208 clk/bit unless noted)
//  1. Reset for 2 cycles then release -> txd=1, busy=0, fifo_level=0, s_ready=1;
//     txd stays high for 100000 cycles.
//  2. Push 0x41 at 8N1 -> txd low for 5208 cycles, then data bits 1,0,0,0,0,0,1,0,
//     then high; busy high for exactly 10*5208 cycles.
//  3. PARITY=2, push 0x31 -> parity bit 1, frame 11 bits.
//     PARITY=1, push 0x31 -> parity bit 0.
//  4. FIFO_DEPTH=4, s_valid held with 0x01..0x06 -> s_ready low while level=4;
//     all 6 frames are sent in order, start bit directly after each stop, no idle gap.
//  5. Assert reset during data bit 3 of 0x55 with 2 words queued -> txd=1 next edge,
//     level=0, busy=0, no further frames.
//  6. PAYLOAD_BITS=7, STOP_BITS=2, CLK_HZ=1000000, BIT_RATE=100000 (10 clk/bit),
//     push 0x7F -> 0, then 1 x7, then 1 x2; busy for 100 cycles.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-buffered UART transmitter.
package uart_tx_fifo_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Clocks per line bit, truncated.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO. The read word comes straight from the storage registers
// at the read pointer, so it is valid before the pop that consumes it.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // A write is refused when full even if a read frees a slot this cycle.
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO: start, LSB-first data, optional
// parity and 1-2 stop bits, back-to-back frames with no idle gap.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [PAYLOAD_BITS-1:0]       s_data,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [3:0]       LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_e               state;
  tx_state_e               state_nx;
  logic [CNT_W-1:0]        bit_cnt;
  logic [3:0]              bit_idx;
  logic [3:0]              bit_idx_nx;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [PAYLOAD_BITS-1:0] fifo_rd_data;
  logic                    txd_nx;
  logic                    pop;
  logic                    shift;
  logic                    bit_end;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    parity_bit;

  uart_sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign s_ready = !fifo_full;
  assign busy    = (state != ST_IDLE) || (fifo_level != '0);
  assign bit_end = (bit_cnt == CNT_LAST);

  // The shift register rotates rather than shifts, so its XOR is the XOR of
  // the latched word at any point in the frame.
  assign parity_bit = (PARITY == PARITY_EVEN) ? ^shreg : ~^shreg;

  // Bit-period counter: parked at zero while idle, wraps at the end of each bit.
  always_ff @(posedge clk) begin
    if (reset)                          bit_cnt <= '0;
    else if (state == ST_IDLE || bit_end) bit_cnt <= '0;
    else                                bit_cnt <= bit_cnt + 1'b1;
  end

  // Control state and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      uart_txd <= 1'b1;
    end else begin
      state    <= state_nx;
      bit_idx  <= bit_idx_nx;
      uart_txd <= txd_nx;
    end
  end

  // Frame word: loaded on pop, rotated once per data bit.
  always_ff @(posedge clk) begin
    if (pop)        shreg <= fifo_rd_data;
    else if (shift) shreg <= {shreg[0], shreg[PAYLOAD_BITS-1:1]};
  end

  // Next-state, next line level and FIFO pop.
  always_comb begin
    state_nx   = state;
    bit_idx_nx = bit_idx;
    txd_nx     = uart_txd;
    pop        = 1'b0;
    shift      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = ST_START;
          txd_nx   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nx   = ST_DATA;
          bit_idx_nx = '0;
          txd_nx     = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift = 1'b1;
          if (bit_idx == LAST_DATA) begin
            bit_idx_nx = '0;
            if (PARITY != PARITY_NONE) begin
              state_nx = ST_PARITY;
              txd_nx   = parity_bit;
            end else begin
              state_nx = ST_STOP;
              txd_nx   = 1'b1;
            end
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
            txd_nx     = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_nx = ST_STOP;
          txd_nx   = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx == LAST_STOP) begin
            bit_idx_nx = '0;
            if (!fifo_empty) begin
              pop      = 1'b1;
              state_nx = ST_START;
              txd_nx   = 1'b0;
            end else begin
              state_nx = ST_IDLE;
              txd_nx   = 1'b1;
            end
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances at 10 clocks per bit
// (ch0 8N1, ch1 7 data/even parity/2 stop, ch2 8 data/odd parity/1 stop).
// Stimulus pushes hand-computed {parity, data} entries; per-channel line
// decoders pop and compare each received frame.
module tb_uart_tx_fifo;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      sv;
  logic [2:0][7:0] sd;
  wire  [2:0]      rdy;
  wire  [2:0]      txd;
  wire  [2:0]      bsy;
  wire  [2:0]      lvl0, lvl1, lvl2;

  int n_tests = 0;
  int n_fail  = 0;
  int saw_full = 0;
  int frames [3];

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .reset(rst), .s_valid(sv[0]), .s_ready(rdy[0]), .s_data(sd[0]),
    .uart_txd(txd[0]), .busy(bsy[0]), .fifo_level(lvl0));

  uart_tx_fifo #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(7),
                 .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .reset(rst), .s_valid(sv[1]), .s_ready(rdy[1]), .s_data(sd[1][6:0]),
    .uart_txd(txd[1]), .busy(bsy[1]), .fifo_level(lvl1));

  uart_tx_fifo #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8),
                 .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .reset(rst), .s_valid(sv[2]), .s_ready(rdy[2]), .s_data(sd[2]),
    .uart_txd(txd[2]), .busy(bsy[2]), .fifo_level(lvl2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] lvl_of(input int ch);
    case (ch)
      0:       return lvl0;
      1:       return lvl1;
      default: return lvl2;
    endcase
  endfunction

  function automatic void exp_push(input int ch, input logic [8:0] e);
    case (ch)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic bit exp_pop(input int ch, output logic [8:0] e);
    e = '0;
    case (ch)
      0:       begin if (q0.size() == 0) return 1'b0; e = q0.pop_front(); end
      1:       begin if (q1.size() == 0) return 1'b0; e = q1.pop_front(); end
      default: begin if (q2.size() == 0) return 1'b0; e = q2.pop_front(); end
    endcase
    return 1'b1;
  endfunction

  task automatic wait_bits(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Line decoder: samples mid-bit, abandons a frame cut short by reset.
  task automatic monitor(input int ch);
    logic       prev = 1'b1;
    logic       ab, st, stp_ok, par;
    logic [7:0] d;
    logic [8:0] e;
    int         nb, np, ns;
    nb = (ch == 1) ? 7 : 8;
    np = (ch == 1) ? 2 : ((ch == 2) ? 1 : 0);
    ns = (ch == 1) ? 2 : 1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && txd[ch] === 1'b0 && !rst) begin
        ab = 1'b0; d = '0; par = 1'b0; stp_ok = 1'b1;
        wait_bits(4, ab);
        st = txd[ch];
        for (int i = 0; i < nb; i++) begin
          wait_bits(10, ab);
          d[i] = txd[ch];
        end
        if (np != 0) begin
          wait_bits(10, ab);
          par = txd[ch];
        end
        for (int i = 0; i < ns; i++) begin
          wait_bits(10, ab);
          if (txd[ch] !== 1'b1) stp_ok = 1'b0;
        end
        if (!ab) begin
          frames[ch]++;
          if (exp_pop(ch, e)) begin
            check($sformatf("ch%0d start bit", ch), 32'(st), 32'd0);
            check($sformatf("ch%0d data", ch), 32'(d), 32'(e[7:0]));
            if (np != 0) check($sformatf("ch%0d parity", ch), 32'(par), 32'(e[8]));
            check($sformatf("ch%0d stop bits", ch), 32'(stp_ok), 32'd1);
          end else begin
            check($sformatf("ch%0d unexpected frame", ch), 32'(d), 32'hffffffff);
          end
        end
      end
      prev = txd[ch];
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int ch, input logic [7:0] b, input logic p);
    int n = 0;
    sd[ch] = b;
    sv[ch] = 1'b1;
    if (!rdy[ch]) begin
      saw_full++;
      check($sformatf("ch%0d level while not ready", ch), 32'(lvl_of(ch)), 32'd4);
    end
    while (!rdy[ch] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[ch]) begin
      check($sformatf("ch%0d push timeout", ch), 32'd0, 32'd1);
      sv[ch] = 1'b0;
    end else begin
      @(posedge clk);
      exp_push(ch, {p, b});
      @(negedge clk);
      sv[ch] = 1'b0;
    end
  endtask

  // Waits for the start bit, then counts busy cycles from the falling edge.
  task automatic time_frame(input int ch, input int exp_cycles, input string name);
    int n = 0;
    while (txd[ch] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " start seen"}, 32'(n < 50), 32'd1);
    n = 0;
    while (bsy[ch] && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_low;
    frames = '{0, 0, 0};
    rst = 1'b1;
    sv  = '0;
    sd  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset txd", 32'(txd), 32'h7);
    check("reset busy", 32'(bsy), 32'h0);
    check("reset level", 32'(lvl0), 32'd0);
    @(negedge clk);
    check("ready after reset", 32'(rdy), 32'h7);
    n_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 3'b111) n_low++;
    end
    check("idle line stays high", 32'(n_low), 32'd0);

    // 8N1 single frame, push-to-start latency
    push(0, 8'h41, 1'b0);
    check("latency level after push", 32'(lvl0), 32'd1);
    check("latency txd before start", 32'(txd[0]), 32'd1);
    @(negedge clk);
    check("latency txd start", 32'(txd[0]), 32'd0);
    check("latency level after pop", 32'(lvl0), 32'd0);
    time_frame(0, 100, "8N1 0x41");
    repeat (20) @(negedge clk);

    // Parity, 7-bit payload and two stop bits
    push(1, 8'h31, 1'b1);
    time_frame(1, 110, "7E2 0x31");
    push(2, 8'h31, 1'b0);
    time_frame(2, 110, "8O1 0x31");
    push(2, 8'h00, 1'b1);
    time_frame(2, 110, "8O1 0x00");
    push(1, 8'h7F, 1'b1);
    time_frame(1, 110, "7E2 0x7F");
    push(1, 8'h05, 1'b0);
    time_frame(1, 110, "7E2 0x05");
    repeat (20) @(negedge clk);

    // Held valid, FIFO fills, six frames back to back
    saw_full = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++) push(0, 8'(i), 1'b0);
      end
      time_frame(0, 600, "burst of 6");
    join
    check("fifo reached full", 32'(saw_full > 0), 32'd1);
    repeat (20) @(negedge clk);

    // Reset during data bit 3 with two words queued
    push(0, 8'h55, 1'b0);
    push(0, 8'hA0, 1'b0);
    push(0, 8'h0F, 1'b0);
    check("queued before abort", 32'(lvl0), 32'd2);
    repeat (43) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort txd", 32'(txd[0]), 32'd1);
    check("abort level", 32'(lvl0), 32'd0);
    check("abort busy", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    check("abort ready", 32'(rdy[0]), 32'd1);
    n_low = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || bsy[0] !== 1'b0) n_low++;
    end
    check("no frames after abort", 32'(n_low), 32'd0);

    check("ch0 frames", 32'(frames[0]), 32'd7);
    check("ch1 frames", 32'(frames[1]), 32'd3);
    check("ch2 frames", 32'(frames[2]), 32'd2);
    check("scoreboard drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
